// File: rtl/xor_cipher_pkg.sv
// Shared types and helpers for the XOR stream cipher: controller state,
// default LFSR feedback mask and the Galois LFSR step.
package xor_cipher_pkg;

    // Controller state: no key loaded yet, or running with a valid key
    typedef enum logic {
        NOKEY = 1'b0,
        RUN   = 1'b1
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

    // One right-shifting Galois step. Operands are carried at 32 bits so the
    // helper serves every legal DATA_W; callers zero-extend and truncate.
    function automatic logic [31:0] lfsr_step(input logic [31:0] key,
                                              input logic [31:0] taps);
        return key[0] ? ((key >> 1) ^ taps) : (key >> 1);
    endfunction

endpackage

// File: rtl/xor_keystream_gen.sv
// Key register for the XOR stream cipher. Holds either a static key or the
// state of a Galois LFSR that steps once per advance pulse in rolling mode.
module xor_keystream_gen
    import xor_cipher_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(DEFAULT_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              mode,
    input  logic              advance,
    output logic [DATA_W-1:0] key_out
);

    logic [DATA_W-1:0] r_key;
    logic              r_mode;

    // An all-zero LFSR state is a fixed point, so a zero seed in rolling mode
    // is replaced by 1.
    logic [DATA_W-1:0] w_seed_safe;
    assign w_seed_safe = (mode && (seed == '0)) ? {{(DATA_W-1){1'b0}}, 1'b1} : seed;

    // Load has priority; otherwise step the LFSR on each advance in rolling mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key  <= '0;
            r_mode <= 1'b0;
        end else if (load) begin
            r_key  <= w_seed_safe;
            r_mode <= mode;
        end else if (advance && r_mode) begin
            r_key  <= DATA_W'(lfsr_step(32'(r_key), 32'(TAPS)));
        end
    end

    assign key_out = r_key;

endmodule

// File: rtl/xor_stream_cipher.sv
// XOR stream cipher: valid/ready input, one registered output stage, static
// or rolling LFSR key, and a saturating count of accepted words.
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(DEFAULT_TAPS),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_in,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              key_valid,
    output logic [CNT_W-1:0]  beat_cnt
);

    state_t            r_state;
    logic              r_key_valid;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_out_vld_p1;
    logic [DATA_W-1:0] r_out_data_p1;

    logic [DATA_W-1:0] w_key;
    logic              w_in_ready;
    logic              w_accept;

    // Ready only with a key, never during a key load, and only when the
    // output register is empty or being drained this cycle.
    assign w_in_ready = (r_state == RUN) && !key_load && (!r_out_vld_p1 || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    xor_keystream_gen #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_keygen (
        .clk     (clk),
        .rst     (rst),
        .load    (key_load),
        .seed    (key_in),
        .mode    (mode),
        .advance (w_accept),
        .key_out (w_key)
    );

    // Controller FSM, beat counter and key-valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= NOKEY;
            r_key_valid <= 1'b0;
            r_beat_cnt  <= '0;
        end else if (key_load) begin
            r_state     <= RUN;
            r_key_valid <= 1'b1;
            r_beat_cnt  <= '0;
        end else if (w_accept && (r_beat_cnt != {CNT_W{1'b1}})) begin
            r_beat_cnt  <= r_beat_cnt + 1'b1;
        end
    end

    // Stage p0 -> p1: output register, uses the key from before this cycle's advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld_p1  <= 1'b0;
            r_out_data_p1 <= '0;
        end else if (w_accept) begin
            r_out_vld_p1  <= 1'b1;
            r_out_data_p1 <= in_data ^ w_key;
        end else if (out_ready) begin
            r_out_vld_p1  <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_vld_p1;
    assign out_data  = r_out_data_p1;
    assign key_valid = r_key_valid;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench for xor_stream_cipher: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_xor_stream_cipher;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam logic [DATA_W-1:0] TAPS = 8'hB8;

    logic              clk;
    logic              rst;
    logic              key_load;
    logic [DATA_W-1:0] key_in;
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              key_valid;
    logic [CNT_W-1:0]  beat_cnt;

    int n_pass  = 0;
    int n_total = 0;

    xor_stream_cipher #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .key_valid (key_valid),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit                m_have_key;
    logic [DATA_W-1:0] m_seed;
    bit                m_mode;
    int                m_nacc;
    bit                m_out_vld;
    logic [DATA_W-1:0] m_out_data;

    // Key after n LFSR steps from a seed: the polynomial view of a
    // right-shifting Galois register.
    function automatic logic [DATA_W-1:0] key_after(input logic [DATA_W-1:0] s, input int n);
        logic [DATA_W-1:0] k = s;
        for (int i = 0; i < n; i++) begin
            if (k[0]) k = (k >> 1) ^ TAPS;
            else      k = k >> 1;
        end
        return k;
    endfunction

    function automatic logic [DATA_W-1:0] model_key();
        return m_mode ? key_after(m_seed, m_nacc) : m_seed;
    endfunction

    function automatic bit model_ready();
        return m_have_key && !key_load && (!m_out_vld || out_ready);
    endfunction

    function automatic int model_beat();
        int sat = (1 << CNT_W) - 1;
        return (m_nacc > sat) ? sat : m_nacc;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_have_key = 0; m_seed = '0; m_mode = 0; m_nacc = 0;
            m_out_vld = 0; m_out_data = '0;
        end else begin
            if (in_valid && model_ready()) begin
                m_out_data = in_data ^ model_key();
                m_out_vld  = 1;
                m_nacc++;
            end else if (out_ready) begin
                m_out_vld = 0;
            end
            if (key_load) begin
                m_have_key = 1;
                m_mode     = mode;
                m_seed     = (mode && key_in == '0) ? 8'h01 : key_in;
                m_nacc     = 0;
            end
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready",  32'(in_ready),  32'(model_ready()));
            chk("m_out_valid", 32'(out_valid), 32'(m_out_vld));
            if (m_out_vld) chk("m_out_data", 32'(out_data), 32'(m_out_data));
            chk("m_key_valid", 32'(key_valid), 32'(m_have_key));
            chk("m_beat_cnt",  32'(beat_cnt),  32'(model_beat()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_key(input logic [DATA_W-1:0] k, input logic m);
        key_load = 1'b1; key_in = k; mode = m;
        @(negedge clk);
        chk("ready_in_load", 32'(in_ready), 32'd0);
        tick();
        key_load = 1'b0; key_in = '0; mode = 1'b0;
    endtask

    logic [DATA_W-1:0] roll_exp [3];

    initial begin
        rst = 1'b1; key_load = 0; key_in = '0; mode = 0;
        in_valid = 0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
        rst = 1'b0;

        // gating: no key yet
        in_valid = 1; in_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nokey_in_ready",  32'(in_ready),  32'd0);
            chk("nokey_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 0;

        // static key 0x5A, two words of 0x3C
        load_key(8'h5A, 1'b0);
        in_valid = 1; in_data = 8'h3C;
        tick();
        @(negedge clk);
        chk("static_w0", 32'(out_data), 32'h66);
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("static_w1",    32'(out_data), 32'h66);
        chk("static_valid", 32'(out_valid), 32'd1);
        chk("static_beat",  32'(beat_cnt), 32'd2);
        tick();

        // rolling key 0x01, three zero words back-to-back
        roll_exp[0] = 8'h01; roll_exp[1] = 8'hB8; roll_exp[2] = 8'h5C;
        load_key(8'h01, 1'b1);
        in_valid = 1; in_data = 8'h00;
        @(negedge clk);
        chk("roll_ready0", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) in_valid = 0;
            @(negedge clk);
            chk("roll_out", 32'(out_data), 32'(roll_exp[i]));
            if (i < 2) chk("roll_ready", 32'(in_ready), 32'd1);
        end
        tick();

        // zero-seed guard
        load_key(8'h00, 1'b1);
        in_valid = 1; in_data = 8'hFF;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("zero_seed", 32'(out_data), 32'hFE);
        tick();

        // backpressure with rolling key 0x01
        load_key(8'h01, 1'b1);
        in_valid = 1; in_data = 8'h00; out_ready = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data",  32'(out_data),  32'h01);
            chk("bp_hold_ready", 32'(in_ready),  32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            if (i < 2) tick();
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("bp_next", 32'(out_data), 32'hB8);
        chk("bp_beat", 32'(beat_cnt), 32'd2);
        out_ready = 0;
        tick();

        // reload while a word is pending and stalled
        in_valid = 1; in_data = 8'h11;
        load_key(8'h33, 1'b0);
        in_valid = 0;
        @(negedge clk);
        chk("reload_pending_data",  32'(out_data),  32'hB8);
        chk("reload_pending_valid", 32'(out_valid), 32'd1);
        chk("reload_beat",          32'(beat_cnt),  32'd0);
        out_ready = 1;
        tick();
        in_valid = 1; in_data = 8'h00;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("reload_new_key", 32'(out_data), 32'h33);
        tick();

        // beat counter saturation
        load_key(8'h0F, 1'b0);
        in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 0;
        @(negedge clk);
        chk("beat_saturated", 32'(beat_cnt), 32'd15);
        chk("sat_last_data",  32'(out_data), 32'(8'd19 ^ 8'h0F));
        tick();

        // reset mid-stream
        load_key(8'h5A, 1'b0);
        in_valid = 1; in_data = 8'hA5; out_ready = 0;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid",     32'(out_valid), 32'd0);
        chk("async_rst_key_valid", 32'(key_valid), 32'd0);
        chk("async_rst_data",      32'(out_data),  32'd0);
        tick();
        rst = 1'b0; out_ready = 1; in_valid = 1; in_data = 8'h12;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 0;
        load_key(8'h21, 1'b0);
        in_valid = 1; in_data = 8'h12;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("post_rst_word", 32'(out_data), 32'h33);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
